// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the scrubbed register file.
package regfile_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SCRUB = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 2;

endpackage

// File: rtl/regfile_scrub_ctrl.sv
// Scrub sequencer: walks every entry once after reset or a clear request,
// then holds READY high while the register file is open for writes.
module regfile_scrub_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_srst,
    input  logic              i_clear,
    output logic              o_scrub_we,
    output logic [ADDR_W-1:0] o_scrub_addr,
    output logic              o_ready
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] SC_LAST = (ADDR_W + 1)'(DEPTH - 1);

    state_t          r_state;
    logic [ADDR_W:0] r_sc;
    logic            r_ready;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_state <= ST_SCRUB;
            r_sc    <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                // A clear request while scrubbing is ignored; the count runs on.
                ST_SCRUB: begin
                    if (r_sc == SC_LAST) begin
                        r_state <= ST_IDLE;
                        r_sc    <= '0;
                        r_ready <= 1'b1;
                    end else begin
                        r_sc <= r_sc + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (i_clear) begin
                        r_state <= ST_SCRUB;
                        r_sc    <= '0;
                        r_ready <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_scrub_we   = (r_state == ST_SCRUB);
    assign o_scrub_addr = r_sc[ADDR_W-1:0];
    assign o_ready      = r_ready;

endmodule

// File: rtl/regfile_scrub.sv
// Two-read / one-write register file with write-first forwarding, optional
// hard-wired zero entry, and a scrub sequencer that zeroes storage.
module regfile_scrub
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLEAR,
    input  logic              REGDST,
    input  logic              REGWRITE,
    input  logic [ADDR_W-1:0] REG_SOURCE,
    input  logic [ADDR_W-1:0] REG_TWO,
    input  logic [ADDR_W-1:0] REG_DEST,
    input  logic [DATA_W-1:0] REG_WRITE_DATA,
    output logic [DATA_W-1:0] READ_DATA_ONE,
    output logic [DATA_W-1:0] READ_DATA_TWO,
    output logic              READY
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic                       w_scrub_we;
    logic [ADDR_W-1:0]          w_scrub_addr;
    logic [ADDR_W-1:0]          w_wa;
    logic                       w_wr_eff;
    logic [1:0][ADDR_W-1:0]     w_raddr;
    logic [DATA_W-1:0]          r_mem [DEPTH];

    regfile_scrub_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_ctrl (
        .i_clk        (CLK),
        .i_srst       (RST),
        .i_clear      (CLEAR),
        .o_scrub_we   (w_scrub_we),
        .o_scrub_addr (w_scrub_addr),
        .o_ready      (READY)
    );

    assign w_wa = REGDST ? REG_DEST : REG_TWO;

    // A write that collides with a clear request or reset is dropped outright.
    assign w_wr_eff = REGWRITE && !w_scrub_we && !CLEAR && !RST
                      && !((ZERO_REG != 0) && (w_wa == '0));

    always_ff @(posedge CLK) begin
        if (w_scrub_we) begin
            r_mem[w_scrub_addr] <= '0;
        end else if (w_wr_eff) begin
            r_mem[w_wa] <= REG_WRITE_DATA;
        end
    end

    assign w_raddr = {REG_TWO, REG_SOURCE};

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic [DATA_W-1:0] w_fwd;
        logic [DATA_W-1:0] r_rdata;

        always_comb begin
            if ((ZERO_REG != 0) && (w_raddr[gi] == '0)) begin
                w_fwd = '0;
            end else if (w_wr_eff && (w_wa == w_raddr[gi])) begin
                w_fwd = REG_WRITE_DATA;
            end else begin
                w_fwd = r_mem[w_raddr[gi]];
            end
        end

        always_ff @(posedge CLK) begin
            if (RST || w_scrub_we) begin
                r_rdata <= '0;
            end else begin
                r_rdata <= w_fwd;
            end
        end
    end

    assign READ_DATA_ONE = g_rd[0].r_rdata;
    assign READ_DATA_TWO = g_rd[1].r_rdata;

endmodule

// File: tb/tb_regfile_scrub.sv
// Directed bench: default instance, zero-register instance and a wide/deep
// instance, each step checked against hand-computed values.
module tb_regfile_scrub;

    logic       clk = 1'b0;
    logic       rst, clear, regdst, regwrite;
    logic [1:0] rs, rt, rd;
    logic [7:0] wd;
    logic [7:0] a_rd1, a_rd2, z_rd1, z_rd2;
    logic       a_rdy, z_rdy;

    logic        p_rst, p_clear, p_regdst, p_regwrite;
    logic [3:0]  p_rs, p_rt, p_rd;
    logic [15:0] p_wd, p_rd1, p_rd2;
    logic        p_rdy;

    int n_total = 0;
    int n_pass  = 0;
    int cnt;

    always #5 clk = ~clk;

    regfile_scrub #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0)) dut_a (
        .CLK(clk), .RST(rst), .CLEAR(clear), .REGDST(regdst), .REGWRITE(regwrite),
        .REG_SOURCE(rs), .REG_TWO(rt), .REG_DEST(rd), .REG_WRITE_DATA(wd),
        .READ_DATA_ONE(a_rd1), .READ_DATA_TWO(a_rd2), .READY(a_rdy)
    );

    regfile_scrub #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1)) dut_z (
        .CLK(clk), .RST(rst), .CLEAR(clear), .REGDST(regdst), .REGWRITE(regwrite),
        .REG_SOURCE(rs), .REG_TWO(rt), .REG_DEST(rd), .REG_WRITE_DATA(wd),
        .READ_DATA_ONE(z_rd1), .READ_DATA_TWO(z_rd2), .READY(z_rdy)
    );

    regfile_scrub #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) dut_p (
        .CLK(clk), .RST(p_rst), .CLEAR(p_clear), .REGDST(p_regdst), .REGWRITE(p_regwrite),
        .REG_SOURCE(p_rs), .REG_TWO(p_rt), .REG_DEST(p_rd), .REG_WRITE_DATA(p_wd),
        .READ_DATA_ONE(p_rd1), .READ_DATA_TWO(p_rd2), .READY(p_rdy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; regdst = 1'b1; regwrite = 1'b0;
        rs = 2'd0; rt = 2'd0; rd = 2'd0; wd = 8'h00;
        p_rst = 1'b1; p_clear = 1'b0; p_regdst = 1'b1; p_regwrite = 1'b0;
        p_rs = 4'd0; p_rt = 4'd0; p_rd = 4'd0; p_wd = 16'h0000;

        // Reset scrub with a write held active the whole time
        tick();
        chk("rst_ready", a_rdy, 0);
        chk("rst_rd1", a_rd1, 0);
        chk("rst_rd2", a_rd2, 0);
        rst = 1'b0; regwrite = 1'b1; regdst = 1'b1; rd = 2'd2; wd = 8'h55;
        cnt = 0;
        while (!a_rdy && cnt < 40) begin
            tick();
            cnt++;
        end
        regwrite = 1'b0;
        chk("scrub_len", cnt, 4);
        chk("z_ready", z_rdy, 1);
        for (int i = 0; i < 4; i++) begin
            rs = 2'(i); rt = 2'(i);
            tick();
            chk($sformatf("scrub_zero1_%0d", i), a_rd1, 0);
            chk($sformatf("scrub_zero2_%0d", i), a_rd2, 0);
        end

        // Write through REG_DEST, read back next cycle
        regwrite = 1'b1; regdst = 1'b1; rd = 2'd2; wd = 8'hA5; rs = 2'd0; rt = 2'd0;
        tick();
        regwrite = 1'b0; rs = 2'd2;
        tick();
        chk("wr_dest_rd1", a_rd1, 8'hA5);

        // Write through REG_TWO; port two forwards it on the same edge
        regwrite = 1'b1; regdst = 1'b0; rt = 2'd1; wd = 8'h3C; rs = 2'd0; rd = 2'd3;
        tick();
        chk("wr_two_fwd_rd2", a_rd2, 8'h3C);
        regwrite = 1'b0; rs = 2'd1;
        tick();
        chk("wr_two_rd1", a_rd1, 8'h3C);

        // Both ports forward the same in-flight write
        regwrite = 1'b1; regdst = 1'b1; rd = 2'd3; wd = 8'h77; rs = 2'd3; rt = 2'd3;
        tick();
        chk("fwd_rd1", a_rd1, 8'h77);
        chk("fwd_rd2", a_rd2, 8'h77);
        chk("fwd_z_rd1", z_rd1, 8'h77);

        // Entry 0: hard-wired zero on dut_z, ordinary on dut_a
        rd = 2'd0; wd = 8'hFF; rs = 2'd0; rt = 2'd0;
        tick();
        chk("zero_fwd_z_rd1", z_rd1, 0);
        chk("zero_fwd_z_rd2", z_rd2, 0);
        chk("zero_fwd_a_rd1", a_rd1, 8'hFF);
        regwrite = 1'b0;
        tick();
        chk("zero_held_z_rd1", z_rd1, 0);
        chk("zero_held_a_rd2", a_rd2, 8'hFF);

        // Load entries with 1..4, then clear colliding with a write to entry 1
        regwrite = 1'b1; regdst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd = 2'(i); wd = 8'(i + 1);
            tick();
        end
        rs = 2'd2; rt = 2'd3; regwrite = 1'b0;
        tick();
        chk("load_rd1", a_rd1, 8'h03);
        chk("load_rd2", a_rd2, 8'h04);
        clear = 1'b1; regwrite = 1'b1; rd = 2'd1; wd = 8'hEE; rs = 2'd1; rt = 2'd1;
        tick();
        chk("clr_drop_rd1", a_rd1, 8'h02);
        chk("clr_drop_z_rd2", z_rd2, 8'h02);
        chk("clr_ready", a_rdy, 0);
        clear = 1'b0; regwrite = 1'b0;
        cnt = 0;
        while (!a_rdy && cnt < 40) begin
            tick();
            cnt++;
            clear = (cnt == 1);
            if (cnt == 1) chk("clr_scrub_rd1", a_rd1, 0);
        end
        clear = 1'b0;
        chk("clr_len", cnt, 4);
        for (int i = 0; i < 4; i++) begin
            rs = 2'(i); rt = 2'(i);
            tick();
            chk($sformatf("clr_zero_%0d", i), a_rd1, 0);
        end

        // Wide/deep instance: reset again at scrub cycle 7
        tick();
        p_rst = 1'b0;
        repeat (7) tick();
        chk("p_mid_ready", p_rdy, 0);
        p_rst = 1'b1;
        tick();
        chk("p_rst_ready", p_rdy, 0);
        p_rst = 1'b0;
        cnt = 0;
        while (!p_rdy && cnt < 80) begin
            tick();
            cnt++;
        end
        chk("p_scrub_len", cnt, 16);
        p_regwrite = 1'b1; p_regdst = 1'b1; p_rd = 4'd15; p_wd = 16'hBEEF;
        tick();
        p_regwrite = 1'b0; p_rs = 4'd15; p_rt = 4'd15;
        tick();
        chk("p_rd1", p_rd1, 16'hBEEF);
        chk("p_rd2", p_rd2, 16'hBEEF);
        p_rs = 4'd14;
        tick();
        chk("p_rd1_other", p_rd1, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
